// File: rtl/axil_regfile_if.sv
// axil_regfile_if: AXI4-Lite bus bundle between a master and the axil_regfile slave.
// Carries the AW, W, B, AR and R channels. DATA_W is the data width and ADDR_W the byte-address width.
// The master modport drives valids, addresses, data and the B/R readies; the slave modport drives the rest.
interface axil_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_regfile.sv
// axil_regfile: parametrised AXI4-Lite slave register file with flat register outputs and write pulses.
// Ports: i_clk (clock), i_axi_reset_n (async active-low reset), s_axi (axil_regfile_if.slave bus),
//        o_regs (register k at [k*W +: W]), o_wr_pulse (one-cycle pulse per written register).
// Option: define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_regfile #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS         = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_axi_reset_n,
    axil_regfile_if.slave                        s_axi,
    output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]                  o_wr_pulse
);
    localparam int DW      = C_AXI_DATA_WIDTH;
    localparam int NB      = DW / 8;
    localparam int ADDRLSB = $clog2(NB);
    localparam int IW      = C_AXI_ADDR_WIDTH - ADDRLSB;
    localparam int IW1     = IW + 1;
    localparam logic [IW:0] NREG = IW1'(NUM_REGS);
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic                         aw_full_q, aw_full_d;
    logic [IW-1:0]                aw_idx_q, aw_idx_d;
    logic                         w_full_q, w_full_d;
    logic [DW-1:0]                wdata_q, wdata_d;
    logic [NB-1:0]                wstrb_q, wstrb_d;
    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;
    logic                         rvalid_q, rvalid_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic [DW-1:0]                rdata_q, rdata_d;
    logic [NUM_REGS-1:0][DW-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;
    logic                         aw_hs, w_hs, ar_hs, commit, aw_oor, ar_oor;
    logic [IW-1:0]                ar_idx;
    logic [DW-1:0]                rsel;
    logic                         unused;

    // Readies are gated by reset so they read 0 while the slave is held in reset.
    assign s_axi.awready = i_axi_reset_n & ~aw_full_q;
    assign s_axi.wready  = i_axi_reset_n & ~w_full_q;
    assign s_axi.arready = i_axi_reset_n & ~rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign o_regs        = regs_q;
    assign o_wr_pulse    = wr_pulse_q;

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign ar_idx = s_axi.araddr[C_AXI_ADDR_WIDTH-1:ADDRLSB];
    // A held pair commits only once the previous response has gone or is leaving now.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | s_axi.bready);
    assign aw_oor = {1'b0, aw_idx_q} >= NREG;
    assign ar_oor = {1'b0, ar_idx} >= NREG;
    assign unused = &{1'b0, s_axi.awprot, s_axi.arprot,
                      s_axi.awaddr[ADDRLSB-1:0], s_axi.araddr[ADDRLSB-1:0]};

    always_comb begin
        aw_full_d  = commit ? 1'b0 : (aw_hs | aw_full_q);
        aw_idx_d   = aw_hs ? s_axi.awaddr[C_AXI_ADDR_WIDTH-1:ADDRLSB] : aw_idx_q;
        w_full_d   = commit ? 1'b0 : (w_hs | w_full_q);
        wdata_d    = w_hs ? s_axi.wdata : wdata_q;
        wstrb_d    = w_hs ? s_axi.wstrb : wstrb_q;
        bvalid_d   = commit | (bvalid_q & ~s_axi.bready);
        bresp_d    = commit ? (aw_oor ? OOR_RESP : 2'b00) : bresp_q;
        rvalid_d   = ar_hs | (rvalid_q & ~s_axi.rready);
        regs_d     = regs_q;
        wr_pulse_d = '0;
        rsel       = '0;
        // Out-of-range indices match no k: no update, no pulse, and read data stays 0.
        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit && aw_idx_q == IW'(k)) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < NB; b++)
                    if (wstrb_q[b]) regs_d[k][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
            if (ar_idx == IW'(k)) rsel = regs_q[k];
        end
        // rsel comes from regs_q, so a read on the commit edge returns the pre-write value.
        rdata_d    = ar_hs ? rsel : rdata_q;
        rresp_d    = ar_hs ? (ar_oor ? OOR_RESP : 2'b00) : rresp_q;
    end

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end
endmodule

// File: doc/axil_regfile.md
# axil_regfile

Parametrised AXI4-Lite slave register file, the successor to the fixed 4×32 slave. It exposes `NUM_REGS` software-visible registers of `C_AXI_DATA_WIDTH` bits. Write address and write data are accepted independently and in either order, and both response channels honour backpressure. Every register is driven out flat to the fabric, together with a per-register write pulse.

## Interface
Parameters:
- `C_AXI_DATA_WIDTH`, default 32. Data width in bits; must be 32 or 64.
- `C_AXI_ADDR_WIDTH`, default 4. Byte-address width.
- `NUM_REGS`, default 4. Number of registers, 1..2^(`C_AXI_ADDR_WIDTH` − `ADDRLSB`).
- `ADDRLSB`, derived as log2(`C_AXI_DATA_WIDTH`/8). Register index = `addr[C_AXI_ADDR_WIDTH-1:ADDRLSB]`; low address bits are ignored.

Ports:
- `i_clk` — in, 1. System clock; the single clock.
- `i_axi_reset_n` — in, 1. Reset, asynchronous assert, active-low.
- `i_axi_awvalid` / `i_axi_awready` — in / out, 1 / 1. Write-address handshake.
- `i_axi_awaddr` — in, `C_AXI_ADDR_WIDTH`. Write byte address.
- `i_axi_awprot` — in, 3. Accepted and ignored.
- `i_axi_wvalid` / `i_axi_wready` — in / out, 1 / 1. Write-data handshake.
- `i_axi_wdata` — in, `C_AXI_DATA_WIDTH`. Write data.
- `i_axi_wstrb` — in, `C_AXI_DATA_WIDTH`/8. Byte strobes.
- `i_axi_bvalid` / `i_axi_bready` — out / in, 1 / 1. Write-response handshake.
- `i_axi_bresp` — out, 2. Write response.
- `i_axi_arvalid` / `i_axi_arready` — in / out, 1 / 1. Read-address handshake.
- `i_axi_araddr` — in, `C_AXI_ADDR_WIDTH`. Read byte address.
- `i_axi_arprot` — in, 3. Accepted and ignored.
- `i_axi_rvalid` / `i_axi_rready` — out / in, 1 / 1. Read-data handshake.
- `i_axi_rdata` — out, `C_AXI_DATA_WIDTH`. Read data.
- `i_axi_rresp` — out, 2. Read response.
- `o_regs` — out, `NUM_REGS`×`C_AXI_DATA_WIDTH`. Register `k` sits at bits `[k*W +: W]`.
- `o_wr_pulse` — out, `NUM_REGS`. Bit `k` pulses for one cycle when register `k` is written.

## Operation
Write holding:
- Two holding slots: AW (address) and W (data + strobes), each with a full flag.
- `i_axi_awready` = !aw_full. `i_axi_wready` = !w_full.
- Each slot fills on its own handshake. Order of arrival is free, and both may arrive in the same cycle.

Write commit:
- Commit occurs on the edge where aw_full && w_full && (!bvalid || bready).
- On commit, the target register gets a per-byte merge: each byte takes the new data where its strobe is 1, otherwise keeps its old value.
- The corresponding `o_wr_pulse` bit asserts.
- Both full flags clear, and bvalid is set with bresp = OKAY (2'b00).

Write edge cases:
- `i_axi_wstrb` = 0: no data change, `o_wr_pulse` still fires, response OKAY.
- Index ≥ `NUM_REGS`: no register changes and no pulse fires. The response is set by the Configuration section.

Read:
- `i_axi_arready` = !rvalid.
- On the AR handshake: rdata = register[index], rvalid = 1, rresp = OKAY.
- rdata, rresp and rvalid are held stable until the rready handshake.
- Read of an index ≥ `NUM_REGS`: rdata = 0, rresp per Configuration.

Concurrency:
- Read and write channels operate in parallel.
- A read whose AR handshake falls on the same edge as a commit to the same register returns the pre-write value.

## Timing
Reset state (asynchronous on `i_axi_reset_n` low):
- All registers, `o_regs`, `o_wr_pulse`, bvalid, rvalid, bresp, rresp, rdata and both full flags are 0.
- All three ready outputs are forced to 0 while reset is low. They rise in the first cycle after release.
- Reset mid-transaction drops held AW/W and any pending B/R response; no register update occurs.

Write timing:
- AW and W handshake together on edge E0 → commit on E1. `i_axi_bvalid` and `o_wr_pulse` are high in the cycle after E1.
- `o_regs` shows the new value after E1.
- awready and wready are low between E0 and E1.
- If bvalid is stalled by bready = 0, the next held pair waits in its slots; the slots stay full and the readies stay low.
- Sustained throughput is one write per 2 cycles with bready tied high.

Read timing:
- AR handshake on E0 → rvalid high after E0 (1-cycle latency).
- arready is low while rvalid is high.
- Throughput is one read per 2 cycles.

## Configuration
`AXIL_REGFILE_SLVERR_EN` controls the response to out-of-range accesses (index ≥ `NUM_REGS`):
- Defined: bresp and rresp = SLVERR (2'b10); rdata = 0.
- Undefined: OKAY responses; writes are silently dropped and reads return 0.
- In-range behaviour is identical either way.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x4 with strobe 0xF, AW and W together. Expect bvalid one cycle after the handshake, bresp = 0, `o_wr_pulse` = 4'b0010, `o_regs[63:32]` = 0xDEADBEEF. Read 0x4 → 0xDEADBEEF, rresp = 0.
- W first and AW three cycles later, data 0x11223344 with strobe 0b0101 to reg 2 holding 0xAABBCCDD. Expect reg 2 = 0xAA22CC44; wready low from the W handshake until the commit.
- Hold bready = 0 for 5 cycles after a write, then issue a second AW/W. Expect bvalid held with bresp stable, the second pair accepted into the slots, and its commit on the first edge after bready = 1.
- `NUM_REGS` = 3: write and read address 0xC. With the macro defined, expect bresp = rresp = 2'b10 and rdata = 0, with no register change. Without the macro, expect OKAY.
- Same-edge read and commit to reg 1 (old 0x5, new 0x9). Expect rdata = 0x5 and a later read returning 0x9.
- Drive `i_axi_reset_n` low between the AW handshake and the W handshake. Expect all outputs 0 immediately, no register write, and no bvalid after reset release.
